// File: rtl/fetch_op_queue.sv
// ----------------------------------------------------------------------------
// fetch_op_queue
//
// Decoded-instruction FIFO between fetch/decode and issue/dispatch. Each entry
// holds the decoded fields of one instruction plus its fetch PC. The head
// entry is presented combinationally (first-word fall-through). foq_full is
// the fetch stall back to the processor. A mispredict flush empties the queue.
//
// Ports:
//   clk_in, rst_in      clock, asynchronous active-high reset
//   rdy_in              global ready; low freezes all state (flush included)
//   flush               mispredict flush, drops every entry
//   in_valid, in_*      offered instruction from decode
//   foq_full            queue cannot accept this cycle
//   out_valid, out_*    head entry, valid when the queue is non-empty
//   out_ready           issue stage takes the head entry this cycle
//   count               current occupancy, 0..DEPTH
// ----------------------------------------------------------------------------
module fetch_op_queue #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  flush,

    input  logic                  in_valid,
    input  logic [31:0]           in_pc,
    input  logic [4:0]            in_op,
    input  logic                  in_branch,
    input  logic                  in_ls,
    input  logic                  in_use_imm,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_rs1,
    input  logic [4:0]            in_rs2,
    input  logic [31:0]           in_imm,
    input  logic                  in_jalr,
    output logic                  foq_full,

    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_pc,
    output logic [4:0]            out_op,
    output logic                  out_branch,
    output logic                  out_ls,
    output logic                  out_use_imm,
    output logic [4:0]            out_rd,
    output logic [4:0]            out_rs1,
    output logic [4:0]            out_rs2,
    output logic [31:0]           out_imm,
    output logic                  out_jalr,

    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2 + 1)'(1);

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  op;
        logic        branch;
        logic        ls;
        logic        use_imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        jalr;
    } entry_t;

    entry_t                mem_q [DEPTH];
    entry_t                entry_in;
    entry_t                entry_head;

    logic [DEPTH_LOG2-1:0] head_q, head_d;
    logic [DEPTH_LOG2-1:0] tail_q, tail_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;

    logic                  enq;
    logic                  deq;

    // Full/empty come from the count register only: when head == tail the
    // pointers alone cannot tell the two apart.
    assign foq_full  = (count_q == DEPTH_CNT);
    assign out_valid = (count_q != '0);
    assign count     = count_q;

    assign enq = rdy_in & in_valid  & ~foq_full & ~flush;
    assign deq = rdy_in & out_valid & out_ready & ~flush;

    assign entry_in = '{
        pc:      in_pc,
        op:      in_op,
        branch:  in_branch,
        ls:      in_ls,
        use_imm: in_use_imm,
        rd:      in_rd,
        rs1:     in_rs1,
        rs2:     in_rs2,
        imm:     in_imm,
        jalr:    in_jalr
    };

    // Head entry falls through; contents are meaningless while out_valid=0.
    assign entry_head  = mem_q[head_q];
    assign out_pc      = entry_head.pc;
    assign out_op      = entry_head.op;
    assign out_branch  = entry_head.branch;
    assign out_ls      = entry_head.ls;
    assign out_use_imm = entry_head.use_imm;
    assign out_rd      = entry_head.rd;
    assign out_rs1     = entry_head.rs1;
    assign out_rs2     = entry_head.rs2;
    assign out_imm     = entry_head.imm;
    assign out_jalr    = entry_head.jalr;

    // NOTE: every always_comb output gets a default first so no latch is
    // inferred on paths that do not assign it.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (rdy_in && flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq) tail_d = tail_q + PTR_ONE;
            if (deq) head_d = head_q + PTR_ONE;
            case ({enq, deq})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; occupancy is tracked
    // by count_q, so stale contents are never observed as valid.
    always_ff @(posedge clk_in) begin
        if (enq) mem_q[tail_q] <= entry_in;
    end

endmodule

// File: tb/tb_fetch_op_queue.sv
// ----------------------------------------------------------------------------
// tb_fetch_op_queue
//
// Randomized bench for fetch_op_queue. A SystemVerilog queue models the FIFO
// directly: push on accept, pop on issue, clear on flush/reset. Outputs are
// compared against the model on the falling edge; the model advances on the
// rising edge using the inputs that were stable across it.
// ----------------------------------------------------------------------------
module tb_fetch_op_queue;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  op;
        logic        branch;
        logic        ls;
        logic        use_imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        jalr;
    } instr_t;

    localparam int DEPTH = 8;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    instr_t      cur;

    logic        foq_full;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [4:0]  out_op;
    logic        out_branch;
    logic        out_ls;
    logic        out_use_imm;
    logic [4:0]  out_rd;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [31:0] out_imm;
    logic        out_jalr;
    logic [3:0]  count;

    instr_t      model_q [$];
    bit          last_enq;
    int          errors = 0;
    int          checks = 0;

    fetch_op_queue #(.DEPTH_LOG2(3)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_pc       (cur.pc),
        .in_op       (cur.op),
        .in_branch   (cur.branch),
        .in_ls       (cur.ls),
        .in_use_imm  (cur.use_imm),
        .in_rd       (cur.rd),
        .in_rs1      (cur.rs1),
        .in_rs2      (cur.rs2),
        .in_imm      (cur.imm),
        .in_jalr     (cur.jalr),
        .foq_full    (foq_full),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_op      (out_op),
        .out_branch  (out_branch),
        .out_ls      (out_ls),
        .out_use_imm (out_use_imm),
        .out_rd      (out_rd),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_imm     (out_imm),
        .out_jalr    (out_jalr),
        .count       (count)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic instr_t rand_instr(input logic [31:0] pc);
        instr_t r;
        r.pc      = pc;
        r.op      = 5'($urandom);
        r.branch  = 1'($urandom);
        r.ls      = 1'($urandom);
        r.use_imm = 1'($urandom);
        r.rd      = 5'($urandom);
        r.rs1     = 5'($urandom);
        r.rs2     = 5'($urandom);
        r.imm     = $urandom;
        r.jalr    = 1'($urandom);
        return r;
    endfunction

    task automatic compare_outputs(input string tag);
        instr_t head;
        check({tag, ".out_valid"}, 128'(out_valid), 128'(model_q.size() != 0));
        check({tag, ".count"},     128'(count),     128'(model_q.size()));
        check({tag, ".foq_full"},  128'(foq_full),  128'(model_q.size() == DEPTH));
        if (model_q.size() != 0) begin
            head = model_q[0];
            check({tag, ".head"},
                  128'({out_pc, out_op, out_branch, out_ls, out_use_imm,
                        out_rd, out_rs1, out_rs2, out_imm, out_jalr}),
                  128'(head));
        end
    endtask

    // One clock: check at the falling edge, then apply queue semantics at
    // the rising edge using the pre-edge model occupancy.
    task automatic step(input string tag);
        bit full, do_enq, do_deq;
        @(negedge clk_in);
        compare_outputs(tag);
        @(posedge clk_in);
        last_enq = 1'b0;
        if (!rst_in && rdy_in) begin
            if (flush) begin
                model_q.delete();
            end else begin
                full   = (model_q.size() == DEPTH);
                do_deq = out_ready && (model_q.size() != 0);
                do_enq = in_valid && !full;
                if (do_deq) void'(model_q.pop_front());
                if (do_enq) model_q.push_back(cur);
                last_enq = do_enq;
            end
        end
        #1;
    endtask

    // Offer fresh instructions with out_ready low until the queue holds n.
    task automatic fill_to(input int n, input string tag);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 20 && model_q.size() < n; i++) begin
            step(tag);
            if (last_enq) cur = rand_instr(32'h2000 + 32'(i) * 4);
        end
        in_valid = 1'b0;
        check({tag, ".reached"}, 128'(model_q.size()), 128'(n));
    endtask

    initial begin
        logic [31:0] pc_n;
        int          sent;

        rst_in    = 1'b1;
        rdy_in    = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        cur       = '0;

        // Reset state before any clock edge.
        #2;
        compare_outputs("reset");
        @(negedge clk_in);
        rst_in = 1'b0;
        step("idle");

        // Single pass.
        out_ready = 1'b1;
        cur       = '0;
        cur.pc    = 32'h1000;
        cur.op    = 5'd1;
        cur.imm   = 32'h10;
        in_valid  = 1'b1;
        step("single.offer");
        in_valid  = 1'b0;
        check("single.accepted", 128'(last_enq), 128'(1));
        step("single.head");
        step("single.drained");

        // Fill: 9 offered with out_ready low, 9th held until one dequeue.
        out_ready = 1'b0;
        pc_n      = 32'h0;
        cur       = rand_instr(pc_n);
        in_valid  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            out_ready = (i == 11);
            step("fill");
            if (i == 7) check("fill.full8", 128'(foq_full), 128'(1));
            if (last_enq) begin
                pc_n += 4;
                if (pc_n > 32'h20) in_valid = 1'b0;
                else cur = rand_instr(pc_n);
            end
        end
        check("fill.all_accepted", 128'(pc_n), 128'(32'h24));
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) step("fill.drain");

        // Wrap and order: 20 instructions, out_ready alternating.
        sent     = 0;
        cur      = rand_instr(32'h4000);
        in_valid = 1'b1;
        for (int i = 0; i < 80 && (sent < 20 || model_q.size() != 0); i++) begin
            out_ready = ~i[0];
            step("wrap");
            if (last_enq) begin
                sent++;
                if (sent == 20) in_valid = 1'b0;
                else cur = rand_instr(32'h4000 + 32'(sent) * 4);
            end
        end
        check("wrap.sent", 128'(sent), 128'(20));
        step("wrap.empty");

        // Flush collision at count 5.
        fill_to(5, "flush.fill");
        flush     = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step("flush.edge");
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        step("flush.after");
        check("flush.count", 128'(count), 128'(0));

        // rdy_in stall at count 3 with every other control asserted.
        fill_to(3, "stall.fill");
        rdy_in    = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        flush     = 1'b1;
        for (int i = 0; i < 4; i++) step("stall");
        check("stall.count", 128'(count), 128'(3));
        rdy_in    = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        for (int i = 0; i < 5; i++) step("stall.resume");

        // Asynchronous reset mid-operation.
        fill_to(4, "areset.fill");
        #2;
        rst_in = 1'b1;
        model_q.delete();
        #1;
        compare_outputs("areset");
        @(negedge clk_in);
        rst_in = 1'b0;
        step("areset.after");

        // Random traffic.
        cur = rand_instr($urandom);
        for (int i = 0; i < 400; i++) begin
            rdy_in    = ($urandom_range(0, 9) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            in_valid  = 1'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            step("random");
            if (last_enq) cur = rand_instr($urandom);
        end
        rdy_in = 1'b1;
        flush  = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) step("final.drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
